// File: rtl/rgb2ycbcr_stream.sv
// rtl/rgb2ycbcr_stream.sv - pipelined RGB to YCbCr stream converter with range clamp
//
// Converts one RGB pixel per cycle to YCbCr over a valid/ready stream.
// Two register stages: S1 holds the fixed-point shift-add sums, S2 holds the
// saturated/clamped components and their saturation flags.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   clr_i                     synchronous clear of clip_cnt_o
//   in_valid_i / in_ready_o   input handshake
//   in_r_i, in_g_i, in_b_i    unsigned colour components
//   mode_i                    0 = full range, 1 = studio range (travels with pixel)
//   out_valid_o / out_ready_i output handshake
//   out_y_o, out_cb_o, out_cr_o converted components
//   out_sat_o                 {cr,cb,y} saturated-or-clamped flags
//   clip_cnt_o                saturating count of flagged components delivered
module rgb2ycbcr_stream #(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_r_i,
  input  logic [DATA_W-1:0] in_g_i,
  input  logic [DATA_W-1:0] in_b_i,
  input  logic              mode_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_y_o,
  output logic [DATA_W-1:0] out_cb_o,
  output logic [DATA_W-1:0] out_cr_o,
  output logic [2:0]        out_sat_o,
  output logic [CNT_W-1:0]  clip_cnt_o
);

  localparam int W = DATA_W + FRAC_W + 2;

  localparam logic [W-1:0]      HALF    = W'(1) << (FRAC_W - 1);
  localparam logic [W-1:0]      CHROMA  = W'(1) << (DATA_W - 1 + FRAC_W);
  localparam logic [DATA_W-1:0] LIM_LO  = DATA_W'(16)  << (DATA_W - 8);
  localparam logic [DATA_W-1:0] LIM_YHI = DATA_W'(235) << (DATA_W - 8);
  localparam logic [DATA_W-1:0] LIM_CHI = DATA_W'(240) << (DATA_W - 8);
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  // Returns {flag, value}: negative sums floor to 0, sums past the integer
  // range ceil to all-ones, then studio mode pulls the value into [LIM_LO, hi].
  function automatic logic [DATA_W:0] sat_clamp(input logic [W-1:0] s,
                                                input logic studio,
                                                input logic [DATA_W-1:0] hi);
    logic [DATA_W-1:0] v;
    logic              f;
    if (s[W-1]) begin
      v = '0;
      f = 1'b1;
    end else if (s[W-2]) begin
      v = '1;
      f = 1'b1;
    end else begin
      v = s[W-3:FRAC_W];
      f = 1'b0;
    end
    if (studio) begin
      if (v < LIM_LO) begin
        v = LIM_LO;
        f = 1'b1;
      end else if (v > hi) begin
        v = hi;
        f = 1'b1;
      end
    end
    return {f, v};
  endfunction

  logic              v1_q, v1_d, v2_q, v2_d;
  logic              mode1_q, mode1_d;
  logic [W-1:0]      y1_q, y1_d, cb1_q, cb1_d, cr1_q, cr1_d;
  logic [DATA_W-1:0] y2_q, y2_d, cb2_q, cb2_d, cr2_q, cr2_d;
  logic [2:0]        sat2_q, sat2_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              en1, en2;
  logic [W-1:0]      xr, xg, xb;
  logic [DATA_W:0]   ys, cbs, crs;
  logic [CNT_W+1:0]  cnt_sum;

  // A stage may load when it is empty or its contents move on this cycle.
  assign en2        = ~v2_q | out_ready_i;
  assign en1        = ~v1_q | en2;
  assign in_ready_o = en1;

  assign xr = {2'b00, in_r_i, {FRAC_W{1'b0}}};
  assign xg = {2'b00, in_g_i, {FRAC_W{1'b0}}};
  assign xb = {2'b00, in_b_i, {FRAC_W{1'b0}}};

  always_comb begin
    v1_d    = v1_q;
    mode1_d = mode1_q;
    y1_d    = y1_q;
    cb1_d   = cb1_q;
    cr1_d   = cr1_q;
    if (en1) begin
      v1_d = in_valid_i;
      if (in_valid_i) begin
        mode1_d = mode_i;
        y1_d  = HALF + (xr >> 2) + (xr >> 4) + (xg >> 1) + (xg >> 4) + (xb >> 3);
        cb1_d = HALF + CHROMA - ((xr >> 3) + (xr >> 5)) - ((xg >> 2) + (xg >> 4))
                + (xb >> 1);
        cr1_d = HALF + CHROMA + (xr >> 1) - ((xg >> 1) - (xg >> 4)) - (xb >> 4);
      end
    end
  end

  always_comb begin
    ys     = sat_clamp(y1_q,  mode1_q, LIM_YHI);
    cbs    = sat_clamp(cb1_q, mode1_q, LIM_CHI);
    crs    = sat_clamp(cr1_q, mode1_q, LIM_CHI);
    v2_d   = v2_q;
    y2_d   = y2_q;
    cb2_d  = cb2_q;
    cr2_d  = cr2_q;
    sat2_d = sat2_q;
    if (en2) begin
      v2_d = v1_q;
      if (v1_q) begin
        y2_d   = ys[DATA_W-1:0];
        cb2_d  = cbs[DATA_W-1:0];
        cr2_d  = crs[DATA_W-1:0];
        sat2_d = {crs[DATA_W], cbs[DATA_W], ys[DATA_W]};
      end
    end
  end

  always_comb begin
    cnt_sum = {2'b00, cnt_q} + (CNT_W+2)'(sat2_q[0]) + (CNT_W+2)'(sat2_q[1])
              + (CNT_W+2)'(sat2_q[2]);
    cnt_d   = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (v2_q && out_ready_i) begin
      cnt_d = (cnt_sum > {2'b00, CNT_MAX}) ? CNT_MAX : cnt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      mode1_q <= 1'b0;
      y1_q    <= '0;
      cb1_q   <= '0;
      cr1_q   <= '0;
      y2_q    <= '0;
      cb2_q   <= '0;
      cr2_q   <= '0;
      sat2_q  <= '0;
      cnt_q   <= '0;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      mode1_q <= mode1_d;
      y1_q    <= y1_d;
      cb1_q   <= cb1_d;
      cr1_q   <= cr1_d;
      y2_q    <= y2_d;
      cb2_q   <= cb2_d;
      cr2_q   <= cr2_d;
      sat2_q  <= sat2_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid_o = v2_q;
  assign out_y_o     = y2_q;
  assign out_cb_o    = cb2_q;
  assign out_cr_o    = cr2_q;
  assign out_sat_o   = sat2_q;
  assign clip_cnt_o  = cnt_q;

endmodule
